// File: rtl/nested_struct_beat_packer_if.sv
// Beat-in / struct-out bus of nested_struct_beat_packer.
// The master modport is the feeder/consumer side; the slave modport is the packer itself.
interface nested_struct_beat_packer_if #(
   parameter int BEAT_W = 16
);
   // Valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1.
   // A source keeps valid and its payload stable until that edge. A sink may drop ready at any time.
   logic              in_valid;
   logic              in_ready;
   logic              in_sof;
   logic [BEAT_W-1:0] in_beat;
   logic              out_valid;
   logic              out_ready;
   logic [61:0]       out_data;
   logic              dbg_collect;
   logic [3:0]        dbg_beat_cnt;

   modport master (
      output in_valid, in_sof, in_beat, out_ready,
      input  in_ready, out_valid, out_data, dbg_collect, dbg_beat_cnt
   );

   modport slave (
      input  in_valid, in_sof, in_beat, out_ready,
      output in_ready, out_valid, out_data, dbg_collect, dbg_beat_cnt
   );
endinterface

// File: rtl/nested_struct_beat_packer.sv
// Packs NUM_BEATS framed MSB-first beats into one 62-bit nested_struct_t word behind a registered valid/ready slot.
// Optional saturating framing-error counter on port err_count when NSBP_ERR_CNT_EN is defined.
module nested_struct_beat_packer #(
   parameter int BEAT_W = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   nested_struct_beat_packer_if.slave     bus
`ifdef NSBP_ERR_CNT_EN
   ,
   output logic [7:0]                     err_count
`endif
);

   localparam int         NUM_BEATS = 64 / BEAT_W;
   localparam int         SHIFT_W   = 64 - BEAT_W;
   localparam logic [3:0] LAST_CNT  = 4'(NUM_BEATS - 1);

   generate
      if (BEAT_W != 8 && BEAT_W != 16 && BEAT_W != 32) begin : g_bad_beat_w
         $error("nested_struct_beat_packer: BEAT_W must be 8, 16 or 32");
      end
   endgenerate

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   state_t               r_state;
   logic [3:0]           r_beat_cnt;
   logic [SHIFT_W-1:0]   r_shift;
   logic                 r_out_valid;
   logic [61:0]          r_out_data;

   logic                 w_last;
   logic                 w_in_ready;
   logic                 w_accept;
   logic [61:0]          w_frame;

   // A beat completes the frame only when it is the final non-sof beat of a frame in progress.
   assign w_last     = (r_state == COLLECT) && (r_beat_cnt == LAST_CNT) && !bus.in_sof;
   assign w_in_ready = !(w_last && r_out_valid && !bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;
   // Frame bits [63:62] fall off here and are never looked at.
   assign w_frame    = 62'({r_shift, bus.in_beat});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_beat_cnt  <= '0;
         r_shift     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         if (w_accept) begin
            if (bus.in_sof) begin
               // Start of frame always restarts, abandoning any partial frame.
               r_shift    <= SHIFT_W'(bus.in_beat);
               r_beat_cnt <= 4'd1;
               r_state    <= COLLECT;
            end else if (r_state == COLLECT) begin
               if (w_last) begin
                  r_out_data <= w_frame;
                  r_beat_cnt <= '0;
                  r_state    <= IDLE;
               end else begin
                  r_shift    <= w_frame[SHIFT_W-1:0];
                  r_beat_cnt <= r_beat_cnt + 4'd1;
               end
            end
         end

         if (w_accept && w_last) begin
            r_out_valid <= 1'b1;
         end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

`ifdef NSBP_ERR_CNT_EN
   logic       w_frame_err;
   logic [7:0] r_err_count;

   assign w_frame_err = w_accept &&
                        (((r_state == IDLE) && !bus.in_sof) || ((r_state == COLLECT) && bus.in_sof));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_count <= '0;
      end else if (w_frame_err && (r_err_count != 8'hFF)) begin
         r_err_count <= r_err_count + 8'd1;
      end
   end

   assign err_count = r_err_count;
`endif

   assign bus.in_ready     = w_in_ready;
   assign bus.out_valid    = r_out_valid;
   assign bus.out_data     = r_out_data;
   assign bus.dbg_collect  = (r_state == COLLECT);
   assign bus.dbg_beat_cnt = r_beat_cnt;

endmodule

// File: tb/tb_nested_struct_beat_packer.sv
// Directed bench for nested_struct_beat_packer: a frame-level model checked every cycle plus literal expectations.
// Err-count checks are compiled in when NSBP_ERR_CNT_EN is defined.
module tb_nested_struct_beat_packer;

  localparam int BW = 16;
  localparam int NB = 64 / BW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nested_struct_beat_packer_if #(.BEAT_W(BW)) bus ();
  nested_struct_beat_packer_if #(.BEAT_W(8))  bus8 ();

`ifdef NSBP_ERR_CNT_EN
  logic [7:0] err_count;
  logic [7:0] err_count8;
`endif

  nested_struct_beat_packer #(.BEAT_W(BW)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef NSBP_ERR_CNT_EN
    ,
    .err_count(err_count)
`endif
  );

  nested_struct_beat_packer #(.BEAT_W(8)) u_dut8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8)
`ifdef NSBP_ERR_CNT_EN
    ,
    .err_count(err_count8)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_out   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Frame-level model: beats of the open frame, pending output slot, error count.
  logic [BW-1:0] frame_q[$];
  logic [61:0]   exp_q[$];
  logic          m_valid = 1'b0;
  logic [61:0]   m_data  = '0;
  logic [7:0]    m_err   = '0;
  logic          m_rdy;
  logic          m_done;
  logic [63:0]   m_word;
  logic [61:0]   m_head;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      frame_q.delete();
      exp_q.delete();
      m_valid = 1'b0;
      m_err   = '0;
    end else begin
      m_rdy = !((frame_q.size() == NB - 1) && !bus.in_sof && m_valid && !bus.out_ready);
      chk("in_ready", 64'(bus.in_ready), 64'(m_rdy));
      chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
      if (m_valid) chk("out_data", 64'(bus.out_data), 64'(m_data));
`ifdef NSBP_ERR_CNT_EN
      chk("err_count", 64'(err_count), 64'(m_err));
`endif
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        m_head = (exp_q.size() != 0) ? exp_q.pop_front() : 62'h0;
        chk("drained_struct", 64'(bus.out_data), 64'(m_head));
      end
      m_done = 1'b0;
      if (bus.in_valid && m_rdy) begin
        if (bus.in_sof) begin
          if (frame_q.size() != 0) m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
          frame_q.delete();
          frame_q.push_back(bus.in_beat);
        end else if (frame_q.size() == 0) begin
          m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
        end else begin
          frame_q.push_back(bus.in_beat);
        end
        if (frame_q.size() == NB) begin
          m_word = '0;
          foreach (frame_q[i]) m_word = (m_word << BW) | 64'(frame_q[i]);
          frame_q.delete();
          m_done = 1'b1;
        end
      end
      if (m_done) begin
        m_valid = 1'b1;
        m_data  = m_word[61:0];
        exp_q.push_back(m_word[61:0]);
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic send_beat(input logic sof, input logic [BW-1:0] beat);
    logic acc;
    int   t;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_beat  = beat;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    chk("beat_accepted", 64'(acc), 64'd1);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_beat  = '0;
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int b = 0; b < NB; b++) send_beat(b == 0, f[63 - b*BW -: BW]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_data", 64'(bus.out_data), 64'd0);
    idle(1);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  int n0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_beat   = '0;
    bus.out_ready = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.in_sof    = 1'b0;
    bus8.in_beat   = '0;
    bus8.out_ready = 1'b1;
    idle(3);
    chk("init_out_valid", 64'(bus.out_valid), 64'd0);
    chk("init_out_data", 64'(bus.out_data), 64'd0);
    chk("init_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef NSBP_ERR_CNT_EN
    chk("init_err_count", 64'(err_count), 64'd0);
`endif
    rst = 1'b0;
    idle(2);

    // 1: one frame back-to-back, output one cycle after the last beat
    send_frame(64'h0123_4567_89AB_CDEF);
    chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_out_data", 64'(bus.out_data), 64'h0123_4567_89AB_CDEF);
    chk("t1_addr", 64'(bus.out_data[61:54]), 64'h04);
    idle(3);

    // 2: two frames with the consumer stalled until cycle 20
    n0 = n_out;
    fork
      begin
        send_frame(64'h0123_4567_89AB_CDEF);
        send_frame(64'h0123_4567_89AB_CDEF);
      end
      begin
        bus.out_ready = 1'b0;
        idle(15);
        chk("t2_stall_in_ready", 64'(bus.in_ready), 64'd0);
        chk("t2_hold_valid", 64'(bus.out_valid), 64'd1);
        chk("t2_hold_data", 64'(bus.out_data), 64'h0123_4567_89AB_CDEF);
        idle(5);
        bus.out_ready = 1'b1;
      end
    join
    idle(3);
    chk("t2_two_structs", 64'(n_out - n0), 64'd2);

    // 3: sof inside a frame restarts it
    send_beat(1'b1, 16'h5555);
    send_beat(1'b0, 16'hAAAA);
    send_beat(1'b1, 16'hC0DE);
    send_beat(1'b0, 16'h1111);
    send_beat(1'b0, 16'h2222);
    send_beat(1'b0, 16'h3333);
    chk("t3_out_data", 64'(bus.out_data), 64'h00DE_1111_2222_3333);
`ifdef NSBP_ERR_CNT_EN
    chk("t3_err_count", 64'(err_count), 64'd1);
`endif
    idle(2);

    // 4: stray beats in IDLE are dropped
    pulse_reset();
    n0 = n_out;
    send_beat(1'b0, 16'hDEAD);
    send_beat(1'b0, 16'hBEEF);
    send_beat(1'b0, 16'hF00D);
    send_frame(64'h0123_4567_89AB_CDEF);
    chk("t4_out_data", 64'(bus.out_data), 64'h0123_4567_89AB_CDEF);
`ifdef NSBP_ERR_CNT_EN
    chk("t4_err_count", 64'(err_count), 64'd3);
`endif
    idle(2);
    chk("t4_one_struct", 64'(n_out - n0), 64'd1);

    // 5: reset mid-frame loses the partial frame without an error
    send_beat(1'b1, 16'h9999);
    send_beat(1'b0, 16'h8888);
    pulse_reset();
    n0 = n_out;
    send_frame(64'h4321_8765_0FED_CBA9);
    chk("t5_out_data", 64'(bus.out_data), 64'h0321_8765_0FED_CBA9);
`ifdef NSBP_ERR_CNT_EN
    chk("t5_err_count", 64'(err_count), 64'd0);
`endif
    idle(2);
    chk("t5_one_struct", 64'(n_out - n0), 64'd1);

    // 7: frames with gaps while the consumer toggles ready
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          for (int b = 0; b < NB; b++) begin
            send_beat(b == 0, 16'($urandom_range(0, 16'hFFFF)));
            idle($urandom_range(0, 2));
          end
        end
      end
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    idle(4);
    chk("all_structs_drained", 64'(exp_q.size()), 64'd0);

    // 6: 8-bit beats, all ones, then saturating error count
    bus8.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus8.in_sof  = (i == 0);
      bus8.in_beat = 8'hFF;
      @(posedge clk);
      #1;
    end
    bus8.in_valid = 1'b0;
    bus8.in_sof   = 1'b0;
    chk("t6_out_valid", 64'(bus8.out_valid), 64'd1);
    chk("t6_out_data", 64'(bus8.out_data), 64'h3FFF_FFFF_FFFF_FFFF);
    idle(2);
    chk("t6_drained", 64'(bus8.out_valid), 64'd0);
    bus8.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus8.in_beat = 8'(i);
      @(posedge clk);
      #1;
    end
    bus8.in_valid = 1'b0;
`ifdef NSBP_ERR_CNT_EN
    chk("t6_err_saturated", 64'(err_count8), 64'hFF);
`endif
    chk("t6_no_struct", 64'(bus8.out_valid), 64'd0);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
